// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA scan-out slice.
//   - Default 640x480@60 timing constants (pixel clocks / lines).
//   - Pixel_Mode encoding (MODE_8BPP, MODE_16BPP).
//   - Colour-expansion helpers producing 4-bit-per-channel RGB.
package vga_pkg;

  localparam int unsigned VgaHActive = 640;
  localparam int unsigned VgaHFp     = 16;
  localparam int unsigned VgaHSync   = 96;
  localparam int unsigned VgaHBp     = 48;
  localparam int unsigned VgaVActive = 480;
  localparam int unsigned VgaVFp     = 10;
  localparam int unsigned VgaVSync   = 2;
  localparam int unsigned VgaVBp     = 33;

  typedef enum logic {
    MODE_8BPP  = 1'b0,
    MODE_16BPP = 1'b1
  } pixel_mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // R3G2B3 byte: replicate MSBs so full-scale codes map to 0xF.
  function automatic rgb444_t unpack_rgb323(input logic [7:0] px);
    rgb444_t c;
    c.r = {px[7:5], px[7]};
    c.g = {px[4:3], px[4:3]};
    c.b = {px[2:0], px[2]};
    return c;
  endfunction

  function automatic rgb444_t unpack_rgb444(input logic [11:0] px);
    rgb444_t c;
    c.r = px[11:8];
    c.g = px[7:4];
    c.b = px[3:0];
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical counters plus combinational decode.
//   clk_i, rst_i      : pixel clock, synchronous active-high reset
//   h_cnt_o, v_cnt_o  : current raster position (stage 0)
//   h_sync_o, v_sync_o: sync levels with polarity already applied
//   active_o          : position lies in the visible area
//   frame_start_o     : position is (0,0)
//   vblank_start_o    : position is (0,V_ACTIVE), first clock of vertical blank
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned HCntW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned VCntW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [HCntW-1:0] h_cnt_o,
  output logic [VCntW-1:0] v_cnt_o,
  output logic             h_sync_o,
  output logic             v_sync_o,
  output logic             active_o,
  output logic             frame_start_o,
  output logic             vblank_start_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HCntW-1:0] h_q;
  logic [VCntW-1:0] v_q;
  logic             h_wrap, v_wrap;
  logic             h_in_sync, v_in_sync;

  assign h_wrap = (32'(h_q) == HTotal - 1);
  assign v_wrap = (32'(v_q) == VTotal - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_wrap ? '0 : h_q + HCntW'(1);
      if (h_wrap) begin
        v_q <= v_wrap ? '0 : v_q + VCntW'(1);
      end
    end
  end

  assign h_in_sync = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
  assign v_in_sync = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);

  assign h_cnt_o        = h_q;
  assign v_cnt_o        = v_q;
  assign h_sync_o       = h_in_sync ? H_POL : ~H_POL;
  assign v_sync_o       = v_in_sync ? V_POL : ~V_POL;
  assign active_o       = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
  assign frame_start_o  = (h_q == '0) && (v_q == '0);
  assign vblank_start_o = (h_q == '0) && (32'(v_q) == V_ACTIVE);

endmodule

// File: rtl/vga_sram_scanout.sv
// vga_sram_scanout: VGA scan-out from asynchronous 16-bit SRAM.
//   CLOCK, RESET            : pixel clock, synchronous active-high reset
//   Pixel_Mode              : 0 = 8bpp R3G2B3, 1 = 16bpp RGB444 (adopted at frame start)
//   Frame_Base, Swap_Req    : next frame buffer, adopted at first clock of vertical blank
//   Swap_Ack                : pulses in the cycle the new base is taken
//   H_Sync, V_Sync, Active  : timing outputs aligned with RGB
//   R_out, G_out, B_out     : 4-bit colour, zero outside the visible area
//   Pixel_X_pos/Pixel_Y_pos : raster position of the pixel on RGB
//   SRAM_Addr, SRAM_Data    : read port; data is sampled the clock after the address
//   Chip_EN..UB             : active-low SRAM controls (read-only use)
// Pipeline: stage 0 counters, stage 1 address/byte selects, stage 2 data -> RGB.
module vga_sram_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VgaHActive,
  parameter int unsigned H_FP     = VgaHFp,
  parameter int unsigned H_SYNC   = VgaHSync,
  parameter int unsigned H_BP     = VgaHBp,
  parameter int unsigned V_ACTIVE = VgaVActive,
  parameter int unsigned V_FP     = VgaVFp,
  parameter int unsigned V_SYNC   = VgaVSync,
  parameter int unsigned V_BP     = VgaVBp,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              Pixel_Mode,
  input  logic [ADDR_W-1:0] Frame_Base,
  input  logic              Swap_Req,
  output logic              Swap_Ack,
  output logic              H_Sync,
  output logic              V_Sync,
  output logic [3:0]        R_out,
  output logic [3:0]        G_out,
  output logic [3:0]        B_out,
  output logic              Active,
  output logic [9:0]        Pixel_X_pos,
  output logic [9:0]        Pixel_Y_pos,
  output logic [ADDR_W-1:0] SRAM_Addr,
  input  logic [15:0]       SRAM_Data,
  output logic              Chip_EN,
  output logic              Write_EN,
  output logic              Out_EN,
  output logic              LB,
  output logic              UB
);

  localparam int unsigned HCntW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VCntW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned IdxW  = ADDR_W + 1;

  // Stage 0
  logic [HCntW-1:0] h_cnt;
  logic [VCntW-1:0] v_cnt;
  logic             hs0, vs0, act0, frame_start, vblank_start;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_POL    (H_POL),
    .V_POL    (V_POL),
    .HCntW    (HCntW),
    .VCntW    (VCntW)
  ) u_timing (
    .clk_i          (CLOCK),
    .rst_i          (RESET),
    .h_cnt_o        (h_cnt),
    .v_cnt_o        (v_cnt),
    .h_sync_o       (hs0),
    .v_sync_o       (vs0),
    .active_o       (act0),
    .frame_start_o  (frame_start),
    .vblank_start_o (vblank_start)
  );

  logic [IdxW-1:0]   idx_q, idx_cur;
  logic [ADDR_W-1:0] cur_base_q, word_off, addr_d;
  pixel_mode_e       cur_mode_q, mode_cur;

  // At (0,0) the index restarts and the freshly sampled mode already governs pixel 0.
  assign idx_cur  = frame_start ? '0 : idx_q;
  assign mode_cur = frame_start ? pixel_mode_e'(Pixel_Mode) : cur_mode_q;
  assign word_off = (mode_cur == MODE_16BPP) ? idx_cur[ADDR_W-1:0] : idx_cur[ADDR_W:1];
  assign addr_d   = cur_base_q + word_off;

  assign Swap_Ack = vblank_start & Swap_Req & ~RESET;

  // Stage 1 side-band
  logic              act1, hs1, vs1, sel_hi1;
  pixel_mode_e       mode1;
  logic [9:0]        x1, y1;

  // Stage 2 colour
  rgb444_t rgb_d;

  always_comb begin
    rgb_d = '0;
    if (act1) begin
      if (mode1 == MODE_16BPP) begin
        rgb_d = unpack_rgb444(SRAM_Data[11:0]);
      end else begin
        rgb_d = unpack_rgb323(sel_hi1 ? SRAM_Data[15:8] : SRAM_Data[7:0]);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      idx_q       <= '0;
      cur_base_q  <= '0;
      cur_mode_q  <= MODE_8BPP;
      SRAM_Addr   <= '0;
      LB          <= 1'b0;
      UB          <= 1'b0;
      act1        <= 1'b0;
      hs1         <= ~H_POL;
      vs1         <= ~V_POL;
      sel_hi1     <= 1'b0;
      mode1       <= MODE_8BPP;
      x1          <= '0;
      y1          <= '0;
      R_out       <= '0;
      G_out       <= '0;
      B_out       <= '0;
      Active      <= 1'b0;
      H_Sync      <= ~H_POL;
      V_Sync      <= ~V_POL;
      Pixel_X_pos <= '0;
      Pixel_Y_pos <= '0;
    end else begin
      // Stage 0 state
      idx_q      <= act0 ? idx_cur + IdxW'(1) : idx_cur;
      cur_mode_q <= mode_cur;
      if (vblank_start && Swap_Req) begin
        cur_base_q <= Frame_Base;
      end
      // Stage 1
      SRAM_Addr <= addr_d;
      if (mode_cur == MODE_16BPP) begin
        LB <= 1'b0;
        UB <= 1'b0;
      end else begin
        LB <= idx_cur[0];
        UB <= ~idx_cur[0];
      end
      act1    <= act0;
      hs1     <= hs0;
      vs1     <= vs0;
      sel_hi1 <= idx_cur[0];
      mode1   <= mode_cur;
      x1      <= 10'(h_cnt);
      y1      <= 10'(v_cnt);
      // Stage 2
      R_out       <= rgb_d.r;
      G_out       <= rgb_d.g;
      B_out       <= rgb_d.b;
      Active      <= act1;
      H_Sync      <= hs1;
      V_Sync      <= vs1;
      Pixel_X_pos <= x1;
      Pixel_Y_pos <= y1;
    end
  end

  assign Chip_EN  = 1'b0;
  assign Out_EN   = 1'b0;
  assign Write_EN = 1'b1;

endmodule

// File: tb/tb_vga_sram_scanout.sv
module tb_vga_sram_scanout;

  localparam int unsigned HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned AW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pixel_mode = 1'b1;
  logic          swap_req = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          swap_ack, h_sync, v_sync, active;
  logic          chip_en, write_en, out_en, lb, ub;
  logic [3:0]    r_out, g_out, b_out;
  logic [9:0]    px, py;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // SRAM: data equals address, except one word holding a known 8bpp pair.
  function automatic logic [15:0] sram_word(input logic [AW-1:0] a);
    if (a == 19'h00200) return 16'hE31C;
    return a[15:0];
  endfunction

  assign sram_data = sram_word(sram_addr);

  vga_sram_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_POL    (1'b0), .V_POL (1'b0), .ADDR_W (AW)
  ) dut (
    .CLOCK       (clk),
    .RESET       (rst),
    .Pixel_Mode  (pixel_mode),
    .Frame_Base  (frame_base),
    .Swap_Req    (swap_req),
    .Swap_Ack    (swap_ack),
    .H_Sync      (h_sync),
    .V_Sync      (v_sync),
    .R_out       (r_out),
    .G_out       (g_out),
    .B_out       (b_out),
    .Active      (active),
    .Pixel_X_pos (px),
    .Pixel_Y_pos (py),
    .SRAM_Addr   (sram_addr),
    .SRAM_Data   (sram_data),
    .Chip_EN     (chip_en),
    .Write_EN    (write_en),
    .Out_EN      (out_en),
    .LB          (lb),
    .UB          (ub)
  );

  // {Chip_EN,Write_EN,Out_EN, Active,H_Sync,V_Sync, X, Y, R,G,B}
  typedef struct { bit rst; logic [37:0] vec; int due; } pix_t;
  typedef struct { logic [AW+1:0] vec; int due; } adr_t;
  typedef struct { logic ack; int due; } ack_t;

  pix_t pix_q[$];
  adr_t adr_q[$];
  ack_t ack_q[$];

  localparam logic [37:0] RstVec = {3'b010, 3'b011, 10'd0, 10'd0, 12'd0};

  // Reference model: raster position from elapsed cycles, pixel from frame index.
  int            t = 0;
  logic [AW-1:0] base_m = '0;
  bit            mode_m = 1'b0;
  pix_t          pend;

  initial begin
    int h, v, idx, word, ai, d, byte_v, r, g, b;
    bit act, hs, vs, lb_e, ub_e;
    logic [AW-1:0] addr_e;
    pend.rst = 1'b1;
    pend.vec = RstVec;
    pend.due = 0;
    forever begin
      @(negedge clk);
      cyc++;
      h = t % HT;
      v = (t / HT) % VT;
      ack_q.push_back('{ack: (h == 0 && v == VA && swap_req && !rst), due: cyc});
      // Previous position reaches the pins next cycle unless a reset flushed it.
      if (pend.rst || rst) pend.vec = RstVec;
      pend.due = cyc + 1;
      pix_q.push_back(pend);

      if (h == 0 && v == 0 && !rst) mode_m = pixel_mode;
      act  = (h < HA) && (v < VA);
      idx  = v * HA + h;
      word = mode_m ? idx : idx / 2;
      ai   = (int'(base_m) + word) % (1 << AW);
      addr_e = ai[AW-1:0];
      d = int'(sram_word(addr_e));
      r = 0; g = 0; b = 0;
      if (act) begin
        if (mode_m) begin
          r = (d / 256) % 16; g = (d / 16) % 16; b = d % 16;
        end else begin
          byte_v = (idx % 2 == 1) ? (d / 256) % 256 : d % 256;
          r = (byte_v / 32) * 2 + (byte_v / 32) / 4;
          g = ((byte_v / 8) % 4) * 5;
          b = (byte_v % 8) * 2 + (byte_v % 8) / 4;
        end
      end
      lb_e = !mode_m && (idx % 2 == 1);
      ub_e = !mode_m && (idx % 2 == 0);
      hs = !((h >= HA + HF) && (h < HA + HF + HS));
      vs = !((v >= VA + VF) && (v < VA + VF + VS));
      pend.rst = rst;
      pend.vec = {3'b010, act, hs, vs, 10'(h), 10'(v), 4'(r), 4'(g), 4'(b)};
      if (rst) adr_q.push_back('{vec: '0, due: cyc + 1});
      else if (act) adr_q.push_back('{vec: {addr_e, lb_e, ub_e}, due: cyc + 1});

      if (rst) begin
        base_m = '0;
        mode_m = 1'b0;
        t = 0;
      end else begin
        if (h == 0 && v == VA && swap_req) base_m = frame_base;
        t++;
      end
    end
  end

  // Monitor: compares whatever the model scheduled for this cycle.
  initial begin
    pix_t pe;
    adr_t ae;
    ack_t ke;
    logic [37:0]   got_p;
    logic [AW+1:0] got_a;
    forever begin
      @(negedge clk);
      #1;
      while (pix_q.size() > 0 && pix_q[0].due < cyc) void'(pix_q.pop_front());
      while (adr_q.size() > 0 && adr_q[0].due < cyc) void'(adr_q.pop_front());
      while (ack_q.size() > 0 && ack_q[0].due < cyc) void'(ack_q.pop_front());
      if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        pe = pix_q.pop_front();
        got_p = {chip_en, write_en, out_en, active, h_sync, v_sync, px, py, r_out, g_out, b_out};
        checks++;
        if (got_p !== pe.vec) begin
          errors++;
          $display("FAIL pixel cyc=%0d got act/hs/vs=%b x=%0d y=%0d rgb=%h ctl=%b want act/hs/vs=%b x=%0d y=%0d rgb=%h ctl=%b",
                   cyc, got_p[34:32], got_p[31:22], got_p[21:12], got_p[11:0], got_p[37:35],
                   pe.vec[34:32], pe.vec[31:22], pe.vec[21:12], pe.vec[11:0], pe.vec[37:35]);
        end
      end
      if (adr_q.size() > 0 && adr_q[0].due == cyc) begin
        ae = adr_q.pop_front();
        got_a = {sram_addr, lb, ub};
        checks++;
        if (got_a !== ae.vec) begin
          errors++;
          $display("FAIL sram_addr cyc=%0d got addr=%h lb/ub=%b want addr=%h lb/ub=%b",
                   cyc, got_a[AW+1:2], got_a[1:0], ae.vec[AW+1:2], ae.vec[1:0]);
        end
      end
      if (ack_q.size() > 0 && ack_q[0].due == cyc) begin
        ke = ack_q.pop_front();
        checks++;
        if (swap_ack !== ke.ack) begin
          errors++;
          $display("FAIL swap_ack cyc=%0d got %b want %b", cyc, swap_ack, ke.ack);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (!swap_req) frame_base = AW'($urandom);
    end
  endtask

  task automatic do_swap(input logic [AW-1:0] b, input int hold_frames);
    bit got;
    got = 1'b0;
    frame_base = b;
    swap_req = 1'b1;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step();
      if (swap_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL swap_wait got no ack want ack within %0d cycles", 2 * FRAME + 4);
    end
    if (hold_frames > 0) begin
      step();
      frame_base = b ^ 19'h00040;
      idle(hold_frames * FRAME);
    end
    step();
    swap_req = 1'b0;
  endtask

  initial begin
    idle(5);
    rst = 1'b0;
    idle(40);
    do_swap(19'h00100, 0);             // frame 1: 16bpp from 0x100
    idle(40);
    pixel_mode = 1'b0;                 // takes effect at next (0,0)
    do_swap(19'h00200, 0);             // frame 2: 8bpp, word 0 = 0xE31C
    idle(30);
    pixel_mode = 1'b1;
    do_swap(19'h04000, 0);             // frame 3: 16bpp from 0x4000
    idle(20);
    do_swap(19'h7FFF8, 1);             // wraps modulo 2^19, held for an extra frame
    for (int k = 0; k < 6; k++) begin
      idle($urandom_range(10, 150));
      pixel_mode = 1'($urandom);
      if ($urandom_range(0, 1) == 1) do_swap(AW'($urandom), $urandom_range(0, 1));
    end
    idle($urandom_range(3, 9));        // reset mid-line
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(FRAME + 17);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2 * FRAME + 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sram_scanout.md
# vga_sram_scanout

Parametrised VGA scan-out engine that generates sync timing, streams pixels from external asynchronous 16-bit SRAM, and drives 4-bit-per-channel RGB. It is the next generation of the fixed 800-wide, 8bpp-only VGA block. It adds parametrised video timing, a runtime 8bpp/16bpp mode, and tear-free double-buffered frame switching at vertical blank. It sits between the frame-buffer SRAM and the VGA DAC pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- H_POL / V_POL, 0 / 0, asserted sync level (0 = active-low)
- ADDR_W, 19, SRAM word-address width

Ports:
- CLOCK  in  1  pixel clock
- RESET  in  1  synchronous, active-high reset
- Pixel_Mode  in  1  0 = 8bpp R3G2B3 (two pixels per word), 1 = 16bpp RGB444 in bits [11:0]
- Frame_Base  in  ADDR_W  word address of the next frame buffer
- Swap_Req  in  1  level; request to adopt Frame_Base
- Swap_Ack  out  1  one-cycle pulse when the new base is applied
- H_Sync, V_Sync  out  1  sync pulses, polarity per H_POL/V_POL
- R_out, G_out, B_out  out  4  colour; 0 outside the active zone
- Active  out  1  high while RGB carries a visible pixel
- Pixel_X_pos, Pixel_Y_pos  out  10  coordinates aligned with RGB
- SRAM_Addr  out  ADDR_W  read address
- SRAM_Data  in  16  read data, valid one clock after address
- Chip_EN, Write_EN, Out_EN, LB, UB  out  1  active-low SRAM controls

## Operation
- Horizontal counter runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. The vertical counter increments when the horizontal counter wraps and itself wraps at V_TOTAL-1.
- The active zone is h < H_ACTIVE and v < V_ACTIVE.
- Sync asserts for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). The same rule applies vertically.
- Pixel index counter: cleared at (h=0, v=0), incremented on every active clock. No multiplier is used.
- 16bpp mode:
  - Address = cur_base + index.
  - LB = UB = 0.
- 8bpp mode:
  - Address = cur_base + (index >> 1).
  - An even index reads the low byte (LB=0, UB=1); an odd index reads the high byte (LB=1, UB=0).
  - Byte layout: R[7:5] G[4:3] B[2:0].
- Colour expansion:
  - 8bpp: R = {r, r[2]}, G = {g, g}, B = {b, b[2]}.
  - 16bpp: R = d[11:8], G = d[7:4], B = d[3:0].
- Chip_EN = 0, Out_EN = 0 and Write_EN = 1 permanently; the block is read-only.
- Pixel_Mode is sampled into cur_mode only at (h=0, v=0). A mid-frame change takes effect the next frame.
- Swap handling:
  - A swap is applied on the first clock of vertical blank (h=0, v=V_ACTIVE).
  - If Swap_Req is high then, cur_base <= Frame_Base and Swap_Ack pulses in that cycle.
  - If Swap_Req is low, cur_base holds.
  - If Swap_Req is held, the swap is re-applied every frame; the requester must drop it after Swap_Ack.

## Timing
- Pipeline has three stages:
  - Stage 0: counters.
  - Stage 1: SRAM_Addr and byte selects registered.
  - Stage 2: SRAM_Data sampled and RGB registered.
- H_Sync, V_Sync, Active and the positions are delayed so they are cycle-aligned with RGB. Total latency from counter to pins is 2 clocks.
- Reset values:
  - Counters, index, Pixel_X_pos, Pixel_Y_pos: 0.
  - cur_base = 0, cur_mode = 0.
  - RGB, Active, Swap_Ack: 0.
  - H_Sync = ~H_POL, V_Sync = ~V_POL.
  - SRAM_Addr = 0, LB = UB = 0.
  - Pipeline stages: cleared.
- Reset mid-frame restarts at (0,0) on the next clock. The first valid pixel appears 2 clocks after RESET is released.
- Counter wrap (H_TOTAL-1 → 0 and V_TOTAL-1 → 0) has no dead cycle.
- Address arithmetic wraps modulo 2^ADDR_W.

## Structure
- Package vga_pkg holds:
  - The 640x480@60 default timing constants.
  - The Pixel_Mode encoding (MODE_8BPP, MODE_16BPP).
  - Colour-expansion functions unpack_rgb323 and unpack_rgb444.
- Sub-module vga_timing contains the H/V counters, sync generation and the active flag, parametrised identically.
- vga_sram_scanout instantiates vga_timing and adds address generation, the swap logic and the two-stage pixel pipeline.

## Test plan
- Reset, then run one frame with H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1:
  - H_Sync is low exactly 2 clocks per 14-clock line.
  - V_Sync is low for 1 line of 7.
  - Active is high for 32 clocks per frame.
- 16bpp with Frame_Base=0x100 and an SRAM model returning data=address:
  - First active pixel shows RGB = 0x1,0x0,0x0.
  - Pixel (x=3, y=1) reads address 0x10B.
  - Output appears exactly 2 clocks after the counter position.
- 8bpp with the word at base = 0xE3_1C:
  - Pixel 0 (LB=0) outputs R=0,G=0xF,B=0x9.
  - Pixel 1 (UB=0) outputs R=0xF,G=0,B=0x6.
  - Both pixels share the same SRAM_Addr.
- Swap_Req raised mid-frame with Frame_Base=0x4000:
  - No address change during the current frame.
  - Swap_Ack pulses once at (h=0, v=V_ACTIVE).
  - The next frame's first address is 0x4000.
- Pixel_Mode toggled mid-frame: addressing stays 8bpp until (0,0), then switches to 16bpp.
- RESET asserted mid-line:
  - All outputs take their reset values on the next clock.
  - Counters restart at (0,0).
  - RGB is 0 until the first pipelined active pixel.
